// File: rtl/icon_compositor.sv
// Layers shot, tank and world pixels into a 2-clock registered VGA colour and pulses hit_a/hit_b
// once per frame on shot/tank overlap; define ICON_COMP_HIT_STATS_EN to build the hits_a/hits_b counters.
module icon_compositor #(
  parameter logic [11:0] WORLD_BG    = 12'hFFF,
  parameter logic [11:0] WORLD_LINE  = 12'h000,
  parameter logic [11:0] WORLD_OBST  = 12'hF00,
  parameter logic [11:0] WORLD_RSVD  = 12'h0F0,
  parameter int          HIT_HOLDOFF = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        video_on,
  input  logic        vsync,
  input  logic [1:0]  world_pixel,
  input  logic [1:0]  icon_a,
  input  logic [11:0] icon_a_c,
  input  logic        burst_a,
  input  logic [1:0]  icon_b,
  input  logic [11:0] icon_b_c,
  input  logic        burst_b,
  input  logic        shot_icon,
  input  logic [11:0] shot_c,
  output logic [11:0] vga_rgb,
  output logic        vga_video_on,
  output logic        hit_a,
  output logic        hit_b,
  output logic [7:0]  hits_a,
  output logic [7:0]  hits_b
);

  localparam int HW = ($clog2(HIT_HOLDOFF + 1) < 1) ? 1 : $clog2(HIT_HOLDOFF + 1);

  typedef struct packed {
    logic        video_on;
    logic        vsync;
    logic [1:0]  world;
    logic [1:0]  icon_a;
    logic [11:0] icon_a_c;
    logic        burst_a;
    logic [1:0]  icon_b;
    logic [11:0] icon_b_c;
    logic        burst_b;
    logic        shot;
    logic [11:0] shot_c;
  } pix_t;

  pix_t          s1_q, s1_d;
  logic          vsync_prev_q;
  logic [11:0]   rgb_q, rgb_d;
  logic          von_q;
  logic [1:0]    ovl_q, ovl_d, ovl_set, hit_q, hit_d;
  logic [HW-1:0] hold_q [2];
  logic [HW-1:0] hold_d [2];
  logic          boundary;

  always_comb begin
    s1_d          = '0;
    s1_d.video_on = video_on;
    s1_d.vsync    = vsync;
    s1_d.world    = world_pixel;
    s1_d.icon_a   = icon_a;
    s1_d.icon_a_c = icon_a_c;
    s1_d.burst_a  = burst_a;
    s1_d.icon_b   = icon_b;
    s1_d.icon_b_c = icon_b_c;
    s1_d.burst_b  = burst_b;
    s1_d.shot     = shot_icon;
    s1_d.shot_c   = shot_c;
  end

  always_comb begin
    unique case (s1_q.world)
      2'd0:    rgb_d = WORLD_BG;
      2'd1:    rgb_d = WORLD_LINE;
      2'd2:    rgb_d = WORLD_OBST;
      default: rgb_d = WORLD_RSVD;
    endcase
    if (!s1_q.video_on)           rgb_d = 12'h000;
    else if (s1_q.shot)           rgb_d = s1_q.shot_c;
    else if (s1_q.icon_a != 2'd0) rgb_d = s1_q.icon_a_c;
    else if (s1_q.icon_b != 2'd0) rgb_d = s1_q.icon_b_c;
  end

  // Falling edge of the stage-1 vsync marks the frame boundary.
  assign boundary = vsync_prev_q & ~s1_q.vsync;

  always_comb begin
    ovl_set[0] = s1_q.video_on & s1_q.shot & (s1_q.icon_a != 2'd0) & ~s1_q.burst_a
                 & (hold_q[0] == '0);
    ovl_set[1] = s1_q.video_on & s1_q.shot & (s1_q.icon_b != 2'd0) & ~s1_q.burst_b
                 & (hold_q[1] == '0);
    for (int t = 0; t < 2; t++) begin
      ovl_d[t]  = ovl_q[t] | ovl_set[t];
      hold_d[t] = hold_q[t];
      hit_d[t]  = 1'b0;
      if (boundary) begin
        // An overlap in the boundary cycle starts the next frame's latch.
        ovl_d[t] = ovl_set[t];
        if (ovl_q[t]) begin
          hit_d[t]  = 1'b1;
          hold_d[t] = HW'(HIT_HOLDOFF);
        end else if (hold_q[t] != '0) begin
          hold_d[t] = hold_q[t] - HW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q         <= '0;
      s1_q.vsync   <= 1'b1;
      vsync_prev_q <= 1'b1;
      rgb_q        <= 12'h000;
      von_q        <= 1'b0;
      ovl_q        <= 2'b00;
      hit_q        <= 2'b00;
      hold_q[0]    <= '0;
      hold_q[1]    <= '0;
    end else begin
      s1_q         <= s1_d;
      vsync_prev_q <= s1_q.vsync;
      rgb_q        <= rgb_d;
      von_q        <= s1_q.video_on;
      ovl_q        <= ovl_d;
      hit_q        <= hit_d;
      hold_q[0]    <= hold_d[0];
      hold_q[1]    <= hold_d[1];
    end
  end

  assign vga_rgb      = rgb_q;
  assign vga_video_on = von_q;
  assign hit_a        = hit_q[0];
  assign hit_b        = hit_q[1];

`ifdef ICON_COMP_HIT_STATS_EN
  logic [7:0] hits_a_q, hits_b_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hits_a_q <= 8'h00;
      hits_b_q <= 8'h00;
    end else begin
      if (hit_d[0] && hits_a_q != 8'hFF) hits_a_q <= hits_a_q + 8'd1;
      if (hit_d[1] && hits_b_q != 8'hFF) hits_b_q <= hits_b_q + 8'd1;
    end
  end

  assign hits_a = hits_a_q;
  assign hits_b = hits_b_q;
`else
  assign hits_a = 8'h00;
  assign hits_b = 8'h00;
`endif

endmodule

// File: tb/tb_icon_compositor.sv
// Directed bench for icon_compositor with a frame-level reference model.
module tb_icon_compositor;
  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        video_on, vsync, burst_a, burst_b, shot_icon;
  logic [1:0]  world_pixel, icon_a, icon_b;
  logic [11:0] icon_a_c, icon_b_c, shot_c;
  logic [11:0] vga_rgb;
  logic        vga_video_on, hit_a, hit_b;
  logic [7:0]  hits_a, hits_b;

  always #5 clk = ~clk;

  icon_compositor #(.HIT_HOLDOFF(HOLD)) dut (
    .clk(clk), .reset(reset), .video_on(video_on), .vsync(vsync),
    .world_pixel(world_pixel), .icon_a(icon_a), .icon_a_c(icon_a_c), .burst_a(burst_a),
    .icon_b(icon_b), .icon_b_c(icon_b_c), .burst_b(burst_b),
    .shot_icon(shot_icon), .shot_c(shot_c),
    .vga_rgb(vga_rgb), .vga_video_on(vga_video_on), .hit_a(hit_a), .hit_b(hit_b),
    .hits_a(hits_a), .hits_b(hits_b)
  );

  typedef struct {
    logic        video_on, vsync, ba, bb, shot;
    logic [1:0]  world, ia, ib;
    logic [11:0] ca, cb, cs;
  } vec_t;

  typedef struct {
    logic [11:0] rgb;
    logic        von, ha, hb;
    logic [7:0]  na, nb;
  } exp_t;

  int   pass_cnt = 0, total_cnt = 0;
  int   na_seen = 0, nb_seen = 0, both_seen = 0;
  bit   chk_en = 0;
  vec_t idle;
  exp_t p0, p1, p2, zero_e;

  // Frame-level model state: overlap seen this frame, holdoff in frames, hit totals.
  bit   m_ovl [2];
  int   m_hold [2];
  int   m_hits [2];
  bit   m_prev_vs;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
  endtask

  function automatic logic [11:0] colour(input vec_t v);
    if (!v.video_on)   return 12'h000;
    if (v.shot)        return v.cs;
    if (v.ia != 2'd0)  return v.ca;
    if (v.ib != 2'd0)  return v.cb;
    case (v.world)
      2'd0:    return 12'hFFF;
      2'd1:    return 12'h000;
      2'd2:    return 12'hF00;
      default: return 12'h0F0;
    endcase
  endfunction

  task automatic model(input vec_t v, output exp_t e);
    bit new_frame;
    bit seen;
    bit hit [2];
    new_frame = m_prev_vs && !v.vsync;
    m_prev_vs = v.vsync;
    e.rgb = colour(v);
    e.von = v.video_on;
    for (int t = 0; t < 2; t++) begin
      seen = v.video_on && v.shot && ((t == 0) ? (v.ia != 0) : (v.ib != 0))
             && !((t == 0) ? v.ba : v.bb) && (m_hold[t] == 0);
      hit[t] = 0;
      if (new_frame) begin
        if (m_ovl[t]) begin
          hit[t]    = 1;
          m_hold[t] = HOLD;
          if (m_hits[t] < 255) m_hits[t]++;
        end else if (m_hold[t] > 0) begin
          m_hold[t]--;
        end
        m_ovl[t] = seen;
      end else begin
        m_ovl[t] = m_ovl[t] || seen;
      end
    end
    e.ha = hit[0];
    e.hb = hit[1];
`ifdef ICON_COMP_HIT_STATS_EN
    e.na = 8'(m_hits[0]);
    e.nb = 8'(m_hits[1]);
`else
    e.na = 8'h00;
    e.nb = 8'h00;
`endif
  endtask

  task automatic drive(input vec_t v);
    video_on = v.video_on; vsync = v.vsync; world_pixel = v.world;
    icon_a = v.ia; icon_a_c = v.ca; burst_a = v.ba;
    icon_b = v.ib; icon_b_c = v.cb; burst_b = v.bb;
    shot_icon = v.shot; shot_c = v.cs;
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    drive(v);
    model(v, e);
    p2 = p1;
    p1 = p0;
    p0 = e;
  endtask

  task automatic do_reset(input bit chk_now);
    exp_t e;
    #2;
    reset  = 1'b1;
    chk_en = 0;
    #1;
    if (chk_now) begin
      chk("async_rst_rgb", vga_rgb, 12'h000);
      chk("async_rst_von", vga_video_on, 1'b0);
      chk("async_rst_hit", {hit_a, hit_b}, 2'b00);
    end
    drive(idle);
    m_ovl[0] = 0; m_ovl[1] = 0; m_hold[0] = 0; m_hold[1] = 0;
    m_hits[0] = 0; m_hits[1] = 0; m_prev_vs = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model(idle, e);
    p0 = e;
    p1 = zero_e;
    p2 = zero_e;
    chk_en = 1;
  endtask

  // Frame: 2 sync cycles, 2 porch, 8 visible, 1 blank.
  task automatic run_frame(input int oa, input int ob, input bit bb, input bit vis, input bit bov);
    vec_t v;
    v = idle; v.vsync = 0;
    if (bov) begin v.video_on = 1; v.shot = 1; v.ia = 2'd1; end
    step(v);
    v = idle; v.vsync = 0; step(v);
    v = idle; step(v); step(v);
    for (int i = 0; i < 8; i++) begin
      v = idle;
      v.video_on = vis;
      v.world = i[1:0];
      v.shot = (i < oa) || (i < ob);
      v.ia = (i < oa) ? 2'd1 : 2'd0;
      v.ib = (i < ob) ? 2'd2 : 2'd0;
      v.bb = bb;
      step(v);
    end
    v = idle; step(v);
  endtask

  task automatic hold3(input vec_t v);
    repeat (3) step(v);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (hit_a) na_seen++;
      if (hit_b) nb_seen++;
      if (hit_a && hit_b) both_seen++;
    end
    if (chk_en && !reset) begin
      chk("rgb", vga_rgb, p2.rgb);
      chk("video_on_o", vga_video_on, p2.von);
      chk("hit_a", hit_a, p2.ha);
      chk("hit_b", hit_b, p2.hb);
      chk("hits_a", hits_a, p2.na);
      chk("hits_b", hits_b, p2.nb);
    end
  end

  initial begin
    vec_t v;
    int ca, cb, cboth;
    idle = '{video_on: 0, vsync: 1, ba: 0, bb: 0, shot: 0, world: 2'd0, ia: 2'd0, ib: 2'd0,
             ca: 12'h0F0, cb: 12'h00F, cs: 12'hFF0};
    zero_e = '{rgb: 12'h000, von: 0, ha: 0, hb: 0, na: 8'h00, nb: 8'h00};
    p0 = zero_e; p1 = zero_e; p2 = zero_e;
    do_reset(0);
    chk("reset_rgb", vga_rgb, 12'h000);
    chk("reset_von", vga_video_on, 1'b0);
    chk("reset_hits", {hit_a, hit_b, hits_a, hits_b}, 18'h0);

    // Layer priority.
    v = idle; v.video_on = 1; v.world = 2'd2; v.ib = 2'd1; v.ia = 2'd1; v.shot = 1;
    hold3(v);
    chk("prio_shot", vga_rgb, 12'hFF0);
    chk("prio_shot_model", p2.rgb, 12'hFF0);
    chk("prio_von", vga_video_on, 1'b1);
    v.shot = 0; hold3(v);
    chk("prio_tank_a", vga_rgb, 12'h0F0);
    v.ia = 2'd0; hold3(v);
    chk("prio_tank_b", vga_rgb, 12'h00F);
    v.ib = 2'd0; hold3(v);
    chk("prio_world", vga_rgb, 12'hF00);
    chk("prio_world_model", p2.rgb, 12'hF00);

    // Blanking.
    v = idle; v.video_on = 0; v.world = 2'd2; v.ia = 2'd1; v.ib = 2'd1; v.shot = 1;
    hold3(v);
    chk("blank_rgb", vga_rgb, 12'h000);
    chk("blank_von", vga_video_on, 1'b0);

    // Single hit and holdoff.
    do_reset(0);
    ca = na_seen; cb = nb_seen;
    run_frame(5, 0, 0, 1, 0);
    run_frame(5, 0, 0, 1, 0);
    chk("single_hit_a", na_seen - ca, 1);
    chk("single_hit_b_quiet", nb_seen - cb, 0);
    repeat (4) run_frame(5, 0, 0, 1, 0);
    chk("holdoff_no_hit", na_seen - ca, 1);
    run_frame(0, 0, 0, 1, 0);
    chk("after_holdoff_hit", na_seen - ca, 2);

    // Burst and off-screen suppression.
    do_reset(0);
    cb = nb_seen;
    run_frame(0, 5, 1, 1, 0);
    run_frame(0, 0, 0, 1, 0);
    chk("burst_b_no_hit", nb_seen - cb, 0);
    do_reset(0);
    ca = na_seen;
    run_frame(5, 0, 0, 0, 0);
    run_frame(0, 0, 0, 1, 0);
    chk("offscreen_no_hit", na_seen - ca, 0);

    // Both tanks in one frame.
    do_reset(0);
    cboth = both_seen;
    run_frame(3, 4, 0, 1, 0);
    run_frame(0, 0, 0, 1, 0);
    chk("both_same_cycle", both_seen - cboth, 1);

    // Overlap only in the boundary cycle.
    do_reset(0);
    ca = na_seen;
    run_frame(0, 0, 0, 1, 1);
    chk("boundary_ovl_defer", na_seen - ca, 0);
    run_frame(0, 0, 0, 1, 0);
    chk("boundary_ovl_next", na_seen - ca, 1);

    // Reset mid-frame discards the latched overlap.
    do_reset(0);
    ca = na_seen;
    run_frame(5, 0, 0, 1, 0);
    v = idle; v.video_on = 1; v.world = 2'd2;
    hold3(v);
    chk("pre_reset_rgb", vga_rgb, 12'hF00);
    do_reset(1);
    run_frame(0, 0, 0, 1, 0);
    run_frame(0, 0, 0, 1, 0);
    chk("reset_discards_ovl", na_seen - ca, 0);

`ifdef ICON_COMP_HIT_STATS_EN
    do_reset(0);
    for (int k = 0; k < 300; k++) begin
      run_frame(1, 0, 0, 1, 0);
      repeat (4) run_frame(0, 0, 0, 1, 0);
    end
    run_frame(0, 0, 0, 1, 0);
    chk("hits_a_saturate", hits_a, 8'hFF);
    chk("hits_b_zero", hits_b, 8'h00);
`endif

    chk_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
